led_pio_sequencer: RTL and testbench

- Avalon-MM master that drives the 8-bit LED PIO slave (data register, address 0). It plays an 8-entry pattern table at a programmable interval.
- Configured through its own zero-wait-state Avalon-MM CSR slave, which sits on the HPS lightweight bridge alongside the PIO.
- Replaces software bit-banging of LED patterns. Sits between the interconnect and the PIO s1 port.

---
 rtl/led_pio_sequencer_pkg.sv | 26 ++
 rtl/led_seq_interval_timer.sv | 37 +++
 rtl/led_pio_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_sequencer_pkg.sv
// Shared definitions for the LED PIO sequencer: CSR map, control/status bit
// positions, FSM states and the PIO register offset.
package led_pio_sequencer_pkg;

  localparam logic [4:0] CSR_CTRL         = 5'd0;
  localparam logic [4:0] CSR_STATUS       = 5'd1;
  localparam logic [4:0] CSR_PERIOD       = 5'd2;
  localparam logic [4:0] CSR_LENGTH       = 5'd3;
  localparam logic [4:0] CSR_PATTERN_BASE = 5'd16;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_STOP_BIT    = 1;
  localparam int CTRL_LOOP_BIT    = 2;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_INDEX_LSB = 8;

  localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/led_seq_interval_timer.sv
// Inter-write interval timer: loaded at write acceptance, expires on the last
// wait cycle so the next write lands exactly PERIOD_eff cycles after acceptance.
module led_seq_interval_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                expired,
  output logic                single_cycle
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // A period of 0 or 1 means back-to-back writes with no wait state at all.
  assign single_cycle = (period <= PERIOD_W'(1));
  assign expired      = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = single_cycle ? '0 : period - PERIOD_W'(2);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// Avalon-MM master that plays a CSR-programmed pattern table into the LED PIO
// data register at a programmable interval.
module led_pio_sequencer
  import led_pio_sequencer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write_n,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic                loop_q, loop_d;
  logic                done_q, done_d;
  logic                stop_pend_q, stop_pend_d;
  logic [DATA_W-1:0]   pattern_q [DEPTH];
  logic [DATA_W-1:0]   pattern_d [DEPTH];
  logic                m_cs_q, m_cs_d;
  logic                m_wn_q, m_wn_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;

  logic             csr_wr, pat_hit, start_cmd, stop_cmd, last_entry;
  logic [IDX_W-1:0] pat_idx, next_idx;
  logic             timer_load, timer_expired, timer_single;

  assign csr_wr     = csr_chipselect && !csr_write_n;
  assign pat_hit    = csr_address[4] && ({1'b0, csr_address[3:0]} < 5'(DEPTH));
  assign pat_idx    = csr_address[IDX_W-1:0];
  assign start_cmd  = csr_wr && (csr_address == CSR_CTRL) &&
                      csr_writedata[CTRL_START_BIT] && !csr_writedata[CTRL_STOP_BIT];
  assign stop_cmd   = csr_wr && (csr_address == CSR_CTRL) && csr_writedata[CTRL_STOP_BIT];
  // Compared with >= so a LENGTH shrunk below the live index ends after this entry.
  assign last_entry = ({1'b0, index_q} + LEN_W'(1)) >= length_q;
  assign next_idx   = last_entry ? '0 : index_q + IDX_W'(1);

  assign busy         = (state_q != ST_IDLE);
  assign m_address    = PIO_DATA_OFFSET;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_wn_q;
  assign m_writedata  = 32'(m_data_q);

  led_seq_interval_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (timer_load),
    .period       (period_q),
    .expired      (timer_expired),
    .single_cycle (timer_single)
  );

  always_comb begin
    csr_readdata = '0;
    if (pat_hit) begin
      csr_readdata = 32'(pattern_q[pat_idx]);
    end else begin
      case (csr_address)
        CSR_CTRL:   csr_readdata[CTRL_LOOP_BIT] = loop_q;
        CSR_STATUS: begin
          csr_readdata[STATUS_BUSY_BIT]          = busy;
          csr_readdata[STATUS_DONE_BIT]          = done_q;
          csr_readdata[STATUS_INDEX_LSB +: 4]    = 4'(index_q);
        end
        CSR_PERIOD: csr_readdata = 32'(period_q);
        CSR_LENGTH: csr_readdata = 32'(length_q);
        default:    csr_readdata = '0;
      endcase
    end
  end

  // CSR register updates first; the FSM below may then override DONE/index.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    period_d    = period_q;
    length_d    = length_q;
    loop_d      = loop_q;
    done_d      = done_q;
    stop_pend_d = stop_pend_q;
    pattern_d   = pattern_q;
    m_cs_d      = m_cs_q;
    m_wn_d      = m_wn_q;
    m_data_d    = m_data_q;
    timer_load  = 1'b0;

    if (csr_wr) begin
      if (pat_hit) begin
        pattern_d[pat_idx] = csr_writedata[DATA_W-1:0];
      end else begin
        case (csr_address)
          CSR_CTRL:   loop_d = csr_writedata[CTRL_LOOP_BIT];
          CSR_STATUS: if (csr_writedata[STATUS_DONE_BIT]) done_d = 1'b0;
          CSR_PERIOD: period_d = csr_writedata[PERIOD_W-1:0];
          CSR_LENGTH: length_d = (csr_writedata > 32'(DEPTH)) ? LEN_W'(DEPTH)
                                                             : csr_writedata[LEN_W-1:0];
          default: ;
        endcase
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_cmd && (length_q != '0)) begin
          state_d     = ST_WRITE;
          index_d     = '0;
          stop_pend_d = 1'b0;
          m_cs_d      = 1'b1;
          m_wn_d      = 1'b0;
          m_data_d    = pattern_q[0];
        end
      end
      ST_WRITE: begin
        if (stop_cmd) stop_pend_d = 1'b1;
        if (!m_waitrequest) begin
          timer_load = 1'b1;
          if (stop_cmd || stop_pend_q) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
            m_cs_d      = 1'b0;
            m_wn_d      = 1'b1;
          end else if (last_entry && !loop_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            m_cs_d  = 1'b0;
            m_wn_d  = 1'b1;
          end else begin
            index_d = next_idx;
            if (timer_single) begin
              m_data_d = pattern_q[next_idx];
            end else begin
              state_d = ST_WAIT;
              m_cs_d  = 1'b0;
              m_wn_d  = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d  = ST_WRITE;
          m_cs_d   = 1'b1;
          m_wn_d   = 1'b0;
          m_data_d = pattern_q[index_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      period_q    <= PERIOD_W'(1);
      length_q    <= LEN_W'(DEPTH);
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      pattern_q   <= '{default: '0};
      m_cs_q      <= 1'b0;
      m_wn_q      <= 1'b1;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      period_q    <= period_d;
      length_q    <= length_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      pattern_q   <= pattern_d;
      m_cs_q      <= m_cs_d;
      m_wn_q      <= m_wn_d;
      m_data_q    <= m_data_d;
    end
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: directed scenarios plus randomized
// runs checked against a timeline model (first write at T+1, next at accept+max(P,1)).
module tb_led_pio_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  csr_address;
   logic        csr_chipselect;
   logic        csr_write_n;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;
   logic        busy;

   int numChecks = 0;
   int numFails  = 0;
   int cyc = 0;

   // Bus monitor records: first presentation cycle/data of every write and its acceptance cycle.
   int          presCyc[$];
   logic [31:0] presData[$];
   int          accCyc[$];
   logic        monHold = 1'b0;
   logic [31:0] monPrevData = '0;

   // Waitrequest driver state: 0 = never stall, 1 = random stalls, 2 = stall write #2 for 3 cycles.
   int   stallMode = 0;
   int   wrNum = 0;
   int   stallCtr = 0;
   logic drvHold = 1'b0;

   logic [7:0] expPat [16];

   led_pio_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .csr_address    (csr_address),
      .csr_chipselect (csr_chipselect),
      .csr_write_n    (csr_write_n),
      .csr_writedata  (csr_writedata),
      .csr_readdata   (csr_readdata),
      .m_address      (m_address),
      .m_chipselect   (m_chipselect),
      .m_write_n      (m_write_n),
      .m_writedata    (m_writedata),
      .m_waitrequest  (m_waitrequest),
      .busy           (busy)
   );

   // 10 ns clock; the cycle counter names the cycle that begins at each rising edge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Compare one observed value with its expected value and report mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Stall the slave according to the selected mode, deciding just after each rising edge.
   initial begin
      m_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (m_chipselect && !m_write_n) begin
            if (!drvHold) begin
               wrNum++;
               stallCtr = 0;
            end
            if (stallMode == 2 && wrNum == 2 && stallCtr < 3) begin
               m_waitrequest = 1'b1;
               stallCtr++;
            end else if (stallMode == 1 && stallCtr < 4 && $urandom_range(0, 2) == 0) begin
               m_waitrequest = 1'b1;
               stallCtr++;
            end else begin
               m_waitrequest = 1'b0;
            end
            drvHold = m_waitrequest;
         end else begin
            m_waitrequest = 1'b0;
            drvHold = 1'b0;
         end
      end
   end

   // Watch the master port mid-cycle, checking address and data stability during stalls.
   always @(negedge clk) begin
      if (!reset && m_chipselect && !m_write_n) begin
         if (monHold) begin
            checkOutput("hold_data", m_writedata, monPrevData);
         end else begin
            presCyc.push_back(cyc);
            presData.push_back(m_writedata);
            checkOutput("m_address", 32'(m_address), 32'd0);
         end
         if (!m_waitrequest) accCyc.push_back(cyc);
         monHold = m_waitrequest;
         monPrevData = m_writedata;
      end else begin
         monHold = 1'b0;
      end
   end

   // Drive one CSR write; at<0 means the next falling edge, else waits for cycle 'at'.
   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                                input int at, output int t);
      @(negedge clk);
      while (at >= 0 && cyc < at) @(negedge clk);
      csr_address    = addr;
      csr_writedata  = data;
      csr_chipselect = 1'b1;
      csr_write_n    = 1'b0;
      t = cyc;
      @(posedge clk);
      #1;
      csr_chipselect = 1'b0;
      csr_write_n    = 1'b1;
   endtask

   task automatic csrWrite(input logic [4:0] addr, input logic [31:0] data);
      int t;
      applyStimulus(addr, data, -1, t);
   endtask

   task automatic csrRead(input logic [4:0] addr, output logic [31:0] data);
      @(negedge clk);
      csr_address    = addr;
      csr_chipselect = 1'b1;
      #1;
      data = csr_readdata;
      csr_chipselect = 1'b0;
   endtask

   task automatic clearMon();
      presCyc.delete();
      presData.delete();
      accCyc.delete();
      wrNum = 0;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic loadPatterns(input int n);
      for (int i = 0; i < n; i++) csrWrite(5'(16 + i), 32'(expPat[i]));
   endtask

   // Reference timeline: write i carries pattern[i mod len]; write 0 at t0+1, write i at accept(i-1)+max(P,1).
   task automatic verifyRun(input string tag, input int t0, input int nWrites,
                            input int len, input int period);
      int peff = (period < 1) ? 1 : period;
      int expT;
      checkOutput({tag, "_count"}, 32'(presCyc.size()), 32'(nWrites));
      for (int i = 0; i < nWrites && i < presCyc.size(); i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), presData[i], 32'(expPat[i % len]));
         if (i == 0) expT = t0 + 1;
         else if (i - 1 < accCyc.size()) expT = accCyc[i - 1] + peff;
         else expT = -1;
         checkOutput($sformatf("%s_time%0d", tag, i), 32'(presCyc[i]), 32'(expT));
      end
   endtask

   initial begin
      logic [31:0] rd;
      int t0, tStop, len, per;

      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rd;
      int t0, tStop, len, per;

      reset = 1'b1;
      csr_address = '0;
      csr_chipselect = 1'b0;
      csr_write_n = 1'b1;
      csr_writedata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      checkOutput("rst_m_chipselect", 32'(m_chipselect), 32'd0);
      checkOutput("rst_m_write_n", 32'(m_write_n), 32'd1);
      checkOutput("rst_m_writedata", m_writedata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      csrRead(5'd2, rd); checkOutput("rst_period", rd, 32'd1);
      csrRead(5'd3, rd); checkOutput("rst_length", rd, 32'd8);
      csrRead(5'd1, rd); checkOutput("rst_status", rd, 32'd0);
      csrRead(5'd0, rd); checkOutput("rst_ctrl", rd, 32'd0);
      csrRead(5'd16, rd); checkOutput("rst_pattern0", rd, 32'd0);
      csrRead(5'd5, rd); checkOutput("unmapped_read", rd, 32'd0);

      // One-shot run of four patterns, period 10
      expPat[0] = 8'h01; expPat[1] = 8'h02; expPat[2] = 8'h04; expPat[3] = 8'h08;
      loadPatterns(4);
      csrWrite(5'd3, 32'd4);
      csrWrite(5'd2, 32'd10);
      csrRead(5'd19, rd); checkOutput("pattern3_readback", rd, 32'h08);
      clearMon();
      applyStimulus(5'd0, 32'h1, -1, t0);
      csrRead(5'd1, rd); checkOutput("status_busy", rd[0] ? 32'd1 : 32'd0, 32'd1);
      waitIdle("oneshot", 200);
      verifyRun("oneshot", t0, 4, 4, 10);
      for (int i = 0; i < 4 && i < presCyc.size(); i++)
         checkOutput($sformatf("oneshot_abs%0d", i), 32'(presCyc[i]), 32'(t0 + 1 + 10 * i));
      checkOutput("oneshot_busy", 32'(busy), 32'd0);
      checkOutput("oneshot_leds_kept", m_writedata, 32'h08);
      csrRead(5'd1, rd); checkOutput("oneshot_done", 32'(rd[1:0]), 32'd2);
      csrWrite(5'd1, 32'h2);
      csrRead(5'd1, rd); checkOutput("done_w1c", 32'(rd[1]), 32'd0);

      // Looping run stopped while waiting
      clearMon();
      applyStimulus(5'd0, 32'h5, -1, t0);
      csrRead(5'd0, rd); checkOutput("ctrl_loop_read", rd, 32'h4);
      applyStimulus(5'd0, 32'h2, t0 + 45, tStop);
      checkOutput("stop_cycle", 32'(tStop), 32'(t0 + 45));
      @(negedge clk);
      checkOutput("stop_busy_next", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      verifyRun("loop", t0, 5, 4, 10);
      csrRead(5'd1, rd); checkOutput("stop_no_done", 32'(rd[1:0]), 32'd0);
      csrWrite(5'd0, 32'h0);

      // Second write stalled for three cycles
      clearMon();
      stallMode = 2;
      applyStimulus(5'd0, 32'h1, -1, t0);
      waitIdle("stall", 200);
      stallMode = 0;
      verifyRun("stall", t0, 4, 4, 10);
      if (presCyc.size() > 2 && accCyc.size() > 1) begin
         checkOutput("stall_hold_len", 32'(accCyc[1] - presCyc[1] + 1), 32'd4);
         checkOutput("stall_third", 32'(presCyc[2]), 32'(t0 + 11 + 3 + 10));
      end else begin
         checkOutput("stall_write_seen", 32'(presCyc.size()), 32'd4);
      end
      csrWrite(5'd1, 32'h2);

      // Period 0 behaves as 1: back-to-back writes
      expPat[0] = 8'hAA; expPat[1] = 8'h55;
      loadPatterns(2);
      csrWrite(5'd2, 32'd0);
      csrWrite(5'd3, 32'd2);
      clearMon();
      applyStimulus(5'd0, 32'h1, -1, t0);
      waitIdle("p0", 50);
      verifyRun("p0", t0, 2, 2, 0);
      if (presCyc.size() > 1) checkOutput("p0_back2back", 32'(presCyc[1]), 32'(t0 + 2));
      csrWrite(5'd1, 32'h2);

      // LENGTH clamp and START with LENGTH=0
      csrWrite(5'd3, 32'd20);
      csrRead(5'd3, rd); checkOutput("length_clamp", rd, 32'd8);
      csrWrite(5'd3, 32'd0);
      clearMon();
      csrWrite(5'd0, 32'h1);
      repeat (10) begin
         @(negedge clk);
         checkOutput("len0_busy", 32'(busy), 32'd0);
      end
      checkOutput("len0_no_writes", 32'(presCyc.size()), 32'd0);
      csrRead(5'd1, rd); checkOutput("len0_no_done", 32'(rd[1]), 32'd0);

      // START and STOP together: STOP wins
      csrWrite(5'd3, 32'd4);
      clearMon();
      csrWrite(5'd0, 32'h3);
      repeat (10) @(negedge clk);
      checkOutput("startstop_busy", 32'(busy), 32'd0);
      checkOutput("startstop_no_writes", 32'(presCyc.size()), 32'd0);

      // Randomized one-shot runs with random stalls
      stallMode = 1;
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(1, 8);
         per = $urandom_range(0, 5);
         for (int i = 0; i < 8; i++) expPat[i] = 8'($urandom);
         loadPatterns(8);
         csrWrite(5'd2, 32'(per));
         csrWrite(5'd3, 32'(len));
         clearMon();
         applyStimulus(5'd0, 32'h1, -1, t0);
         waitIdle($sformatf("rnd%0d", r), 400);
         verifyRun($sformatf("rnd%0d", r), t0, len, len, per);
         csrRead(5'd1, rd); checkOutput($sformatf("rnd%0d_done", r), 32'(rd[1:0]), 32'd2);
         csrWrite(5'd1, 32'h2);
      end
      stallMode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
